// File: rtl/rom_browse_ctrl.sv
// ROM browser: steps an address through a synchronous ROM (auto or per key)
// and shows address and data on a 4-digit multiplexed 7-segment display.
module rom_browse_ctrl #(
   parameter int          ADDR_W   = 8,
   parameter int          DEPTH    = 256,
   parameter logic [23:0] CNT_MAX  = 24'd9_999_999,
   parameter logic [19:0] DEB_MAX  = 20'd999_999,
   parameter logic [15:0] SCAN_MAX = 16'd49_999
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              key1,
   input  logic              key2,
   input  logic [7:0]        rom_data,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              running,
   output logic [3:0]        led_bit,
   output logic [7:0]        led_out
);

   // bit1 = running, bit0 = direction down
   typedef enum logic [1:0] {
      S_HOLD_UP = 2'b00,
      S_HOLD_DN = 2'b01,
      S_RUN_UP  = 2'b10,
      S_RUN_DN  = 2'b11
   } state_t;

   logic [1:0]        w_key;
   logic [1:0]        r_sync0;
   logic [1:0]        r_sync1;
   logic [1:0][19:0]  r_deb_cnt;
   logic [1:0]        r_stable;
   logic [1:0]        r_stable_d;
   logic [1:0]        r_press;

   state_t            r_state;
   state_t            w_state_nx;
   logic [23:0]       r_timer;
   logic [23:0]       w_timer_nx;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_addr_nx;
   logic [ADDR_W-1:0] w_addr_up;
   logic [ADDR_W-1:0] w_addr_dn;
   logic [ADDR_W-1:0] w_addr_step;

   logic [15:0]       r_scan_cnt;
   logic [1:0]        r_idx;
   logic [7:0]        r_data;
   logic [7:0]        w_addr8;
   logic [3:0]        w_nib;
   logic [7:0]        w_seg;
   logic              w_dp_on;
   logic [3:0]        r_led_bit;
   logic [7:0]        r_led_out;

   assign w_key = {key2, key1};

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sync0    <= '0;
         r_sync1    <= '0;
         r_deb_cnt  <= '0;
         r_stable   <= '0;
         r_stable_d <= '0;
         r_press    <= '0;
      end else begin
         r_sync0    <= w_key;
         r_sync1    <= r_sync0;
         r_stable_d <= r_stable;
         r_press    <= r_stable & ~r_stable_d;
         for (int i = 0; i < 2; i++) begin
            if (r_sync1[i] == r_stable[i]) begin
               r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == DEB_MAX) begin
               r_stable[i]  <= r_sync1[i];
               r_deb_cnt[i] <= '0;
            end else begin
               r_deb_cnt[i] <= r_deb_cnt[i] + 20'd1;
            end
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= S_RUN_UP;
         r_timer <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nx;
         r_timer <= w_timer_nx;
         r_addr  <= w_addr_nx;
      end
   end

   always_comb begin
      w_addr_up   = (r_addr == ADDR_W'(DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
      w_addr_dn   = (r_addr == '0) ? ADDR_W'(DEPTH - 1) : r_addr - ADDR_W'(1);
      w_addr_step = r_state[0] ? w_addr_dn : w_addr_up;
   end

   always_comb begin
      w_state_nx = r_state;
      w_timer_nx = r_timer;
      w_addr_nx  = r_addr;
      if (r_state[1]) begin
         if (r_timer == CNT_MAX) begin
            w_timer_nx = '0;
            w_addr_nx  = w_addr_step;
         end else begin
            w_timer_nx = r_timer + 24'd1;
         end
      end
      // key1 wins when both pulses coincide
      unique case (r_press)
         2'b01, 2'b11: begin
            w_state_nx = state_t'({~r_state[1], r_state[0]});
            w_timer_nx = '0;
         end
         2'b10: begin
            if (r_state[1]) begin
               w_state_nx = state_t'({r_state[1], ~r_state[0]});
            end else begin
               w_addr_nx = w_addr_step;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_addr8                = '0;
      w_addr8[ADDR_W-1:0]    = r_addr;
      w_dp_on                = (r_idx == 2'd2) && r_state[1];
      unique case (r_idx)
         2'd0: w_nib = r_data[3:0];
         2'd1: w_nib = r_data[7:4];
         2'd2: w_nib = w_addr8[3:0];
         2'd3: w_nib = w_addr8[7:4];
      endcase
      unique case (w_nib)
         4'h0: w_seg = 8'hC0;
         4'h1: w_seg = 8'hF9;
         4'h2: w_seg = 8'hA4;
         4'h3: w_seg = 8'hB0;
         4'h4: w_seg = 8'h99;
         4'h5: w_seg = 8'h92;
         4'h6: w_seg = 8'h82;
         4'h7: w_seg = 8'hF8;
         4'h8: w_seg = 8'h80;
         4'h9: w_seg = 8'h90;
         4'hA: w_seg = 8'h88;
         4'hB: w_seg = 8'h83;
         4'hC: w_seg = 8'hC6;
         4'hD: w_seg = 8'hA1;
         4'hE: w_seg = 8'h86;
         4'hF: w_seg = 8'h8E;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_scan_cnt <= '0;
         r_idx      <= '0;
         r_data     <= '0;
         r_led_bit  <= 4'b1111;
         r_led_out  <= 8'hFF;
      end else begin
         r_data    <= rom_data;
         r_led_bit <= ~(4'b0001 << r_idx);
         r_led_out <= w_dp_on ? (w_seg & 8'h7F) : w_seg;
         if (r_scan_cnt == SCAN_MAX) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
         end
      end
   end

   assign rom_addr = r_addr;
   assign running  = r_state[1];
   assign led_bit  = r_led_bit;
   assign led_out  = r_led_out;

endmodule

// File: tb/tb_rom_browse_ctrl.sv
// Directed bench for rom_browse_ctrl with small timing parameters
// and a registered ROM model.
module tb_rom_browse_ctrl;

   logic       sys_clk;
   logic       sys_rst_n;
   logic       key1;
   logic       key2;
   logic [7:0] rom_data;
   logic [7:0] rom_addr;
   logic       running;
   logic [3:0] led_bit;
   logic [7:0] led_out;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   rom_browse_ctrl #(
      .ADDR_W  (8),
      .DEPTH   (10),
      .CNT_MAX (24'd99),
      .DEB_MAX (20'd9),
      .SCAN_MAX(16'd4)
   ) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key1     (key1),
      .key2     (key2),
      .rom_data (rom_data),
      .rom_addr (rom_addr),
      .running  (running),
      .led_bit  (led_bit),
      .led_out  (led_out)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial rom_data = 8'h00;
   always @(posedge sys_clk)
      rom_data <= (rom_addr == 8'd3) ? 8'hA5 : {rom_addr[3:0], rom_addr[3:0]};

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         cyc++;
      end
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      key1      = 1'b0;
      key2      = 1'b0;
      sys_rst_n = 1'b1;
      #2 sys_rst_n = 1'b0;
      #1;
      chk("rst_addr", 32'(rom_addr), 32'd0);
      chk("rst_run", 32'(running), 32'd1);
      chk("rst_bit", 32'(led_bit), 32'hF);
      chk("rst_seg", 32'(led_out), 32'hFF);
      repeat (2) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      cyc = 0;

      tick(1);
      chk("first_bit", 32'(led_bit), 32'hE);
      chk("first_seg", 32'(led_out), 32'hC0);

      // auto-step up with wrap at DEPTH-1
      for (int i = 1; i <= 10; i++) begin
         tick(100 * i - 1 - cyc);
         chk("auto_pre", 32'(rom_addr), 32'((i - 1) % 10));
         tick(1);
         chk("auto_post", 32'(rom_addr), 32'(i % 10));
         chk("auto_run", 32'(running), 32'd1);
      end

      // pause
      key1 = 1'b1;
      tick(13);
      chk("pause_pre", 32'(running), 32'd1);
      tick(1);
      chk("pause_post", 32'(running), 32'd0);
      tick(6);
      key1 = 1'b0;
      tick(20);
      chk("pause_frz", 32'(rom_addr), 32'd0);

      // single step, long hold gives one step
      key2 = 1'b1;
      tick(13);
      chk("step_pre", 32'(rom_addr), 32'd0);
      tick(1);
      chk("step_post", 32'(rom_addr), 32'd1);
      tick(36);
      key2 = 1'b0;
      tick(20);
      chk("step_norep", 32'(rom_addr), 32'd1);

      // resume, then reverse
      key1 = 1'b1;
      tick(14);
      chk("resume", 32'(running), 32'd1);
      key1 = 1'b0;
      key2 = 1'b1;
      tick(14);
      tick(6);
      key2 = 1'b0;
      tick(79);
      chk("rev_pre", 32'(rom_addr), 32'd1);
      tick(1);
      chk("rev_1to0", 32'(rom_addr), 32'd0);
      tick(99);
      chk("rev_hold", 32'(rom_addr), 32'd0);
      tick(1);
      chk("rev_0to9", 32'(rom_addr), 32'd9);
      tick(100);
      chk("rev_9to8", 32'(rom_addr), 32'd8);

      // glitch rejection
      key1 = 1'b1;
      tick(5);
      key1 = 1'b0;
      tick(20);
      chk("glitch_run", 32'(running), 32'd1);
      chk("glitch_addr", 32'(rom_addr), 32'd8);

      // simultaneous keys: key1 only
      key1 = 1'b1;
      key2 = 1'b1;
      tick(14);
      chk("both_run", 32'(running), 32'd0);
      chk("both_addr", 32'(rom_addr), 32'd8);
      tick(6);
      key1 = 1'b0;
      key2 = 1'b0;
      tick(20);
      key2 = 1'b1;
      tick(14);
      chk("both_dir", 32'(rom_addr), 32'd7);
      key2 = 1'b0;
      tick(20);

      // step down to 3
      for (int i = 0; i < 4; i++) begin
         key2 = 1'b1;
         tick(14);
         chk("dn_step", 32'(rom_addr), 32'(6 - i));
         key2 = 1'b0;
         tick(20);
      end

      // display scan, paused at 3 with data A5
      while (((cyc - 1) % 20) != 0) tick(1);
      begin
         logic [3:0] eb [4];
         logic [7:0] es [4];
         eb = '{4'hE, 4'hD, 4'hB, 4'h7};
         es = '{8'h92, 8'h88, 8'hB0, 8'hC0};
         for (int d = 0; d < 4; d++) begin
            chk("scan_bit", 32'(led_bit), 32'(eb[d]));
            chk("scan_seg", 32'(led_out), 32'(es[d]));
            tick(4);
            chk("scan_hold", 32'(led_bit), 32'(eb[d]));
            tick(1);
         end
      end

      key1 = 1'b1;
      tick(14);
      chk("disp_resume", 32'(running), 32'd1);
      key1 = 1'b0;
      tick(20);
      while (((cyc - 1) % 20) != 10) tick(1);
      chk("dp_bit", 32'(led_bit), 32'hB);
      chk("dp_seg", 32'(led_out), 32'h30);

      // reset mid-debounce at address 7
      for (int k = 0; k < 1000 && rom_addr != 8'd7; k++) tick(1);
      chk("reach7", 32'(rom_addr), 32'd7);
      key1 = 1'b1;
      tick(5);
      sys_rst_n = 1'b0;
      #1;
      chk("mr_addr", 32'(rom_addr), 32'd0);
      chk("mr_bit", 32'(led_bit), 32'hF);
      chk("mr_seg", 32'(led_out), 32'hFF);
      chk("mr_run", 32'(running), 32'd1);
      key1 = 1'b0;
      repeat (3) @(posedge sys_clk);
      #2 sys_rst_n = 1'b1;
      cyc = 0;
      tick(40);
      chk("mr_lost", 32'(running), 32'd1);
      tick(59);
      chk("mr_pre", 32'(rom_addr), 32'd0);
      tick(1);
      chk("mr_up", 32'(rom_addr), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
